aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption datapath. Accepts a start pulse, loads the plaintext state register, then issues one-cycle enables to the SubBytes, ShiftRows, MixColumns and AddRoundKey stages in AES round order. It fetches each round key through a request/valid handshake with the key-expansion block, skips MixColumns in the final round, and signals completion with a one-cycle `done`. It sits between the accelerator's host-facing control logic and the registered round-stage datapath.

---
 rtl/aes_round_ctrl.sv | 113 +++++++++++
 tb/tb_aes_round_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: orders load/ARK/SubBytes/ShiftRows/MixColumns enables and round-key fetch.
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef AES_CTRL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       key_valid,
    output logic       load_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       key_req,
    output logic [3:0] key_round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_ARK,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       abort_hit;

`ifdef AES_CTRL_ABORT_EN
    assign abort_hit = abort && (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KEY;
                    round_d = 4'd0;
                end
            end
            S_KEY: begin
                if (key_valid) state_d = S_ARK;
            end
            S_ARK: begin
                // Counter saturates at the final round; the last ARK goes straight to DONE.
                if (round_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = S_SUB;
                end
            end
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = (round_q == LAST_ROUND) ? S_KEY : S_MIX;
            S_MIX:   state_d = S_KEY;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) begin
            state_d = S_IDLE;
            round_d = 4'd0;
        end
    end

    always_comb begin
        load_en  = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        mix_en   = 1'b0;
        ark_en   = 1'b0;
        key_req  = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  load_en  = start;
            S_KEY:   key_req  = 1'b1;
            S_ARK:   ark_en   = 1'b1;
            S_SUB:   sub_en   = 1'b1;
            S_SHIFT: shift_en = 1'b1;
            S_MIX:   mix_en   = 1'b1;
            S_DONE:  done     = 1'b1;
            default: ;
        endcase
    end

    assign key_round = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed self-checking bench for aes_round_ctrl (NUM_ROUNDS=10).
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b1;
`ifdef AES_CTRL_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       load_en, sub_en, shift_en, mix_en, ark_en, key_req, busy, done;
    logic [3:0] key_round;

    int n_chk  = 0;
    int n_fail = 0;

    int n_load, n_sub, n_shift, n_mix, n_ark, n_done, done_at;
    int n_kreq4, n_onehot_err, n_mix_late, busy0;
    int keyseq[$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef AES_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .key_valid (key_valid),
        .load_en   (load_en),
        .sub_en    (sub_en),
        .shift_en  (shift_en),
        .mix_en    (mix_en),
        .ark_en    (ark_en),
        .key_req   (key_req),
        .key_round (key_round),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs ncyc cycles; cycle c is the low phase before rising edge c. start
    // pulses at c=0 and at s1/s2; key_valid is held low for wait_len KEY cycles of wait_round.
    task automatic run(input int ncyc, input int wait_round, input int wait_len,
                       input int s1, input int s2);
        int   waited;
        logic prev_kreq;
        logic final_shift_seen;
        int   en_cnt;
        n_load = 0; n_sub = 0; n_shift = 0; n_mix = 0; n_ark = 0; n_done = 0;
        done_at = -1; n_kreq4 = 0; n_onehot_err = 0; n_mix_late = 0; busy0 = -1;
        keyseq.delete();
        waited = 0;
        prev_kreq = 1'b0;
        final_shift_seen = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == s1) || (c == s2);
            key_valid = 1'b1;
            if (key_req && (int'(key_round) == wait_round) && (waited < wait_len)) begin
                key_valid = 1'b0;
                waited++;
            end
            #1;
            if (c == 0) busy0 = int'(busy);
            n_load  += int'(load_en);
            n_sub   += int'(sub_en);
            n_shift += int'(shift_en);
            n_mix   += int'(mix_en);
            n_ark   += int'(ark_en);
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (key_req && !prev_kreq) keyseq.push_back(int'(key_round));
            if (key_req && key_round == 4'd4) n_kreq4++;
            en_cnt = int'(load_en) + int'(sub_en) + int'(shift_en) + int'(mix_en) + int'(ark_en);
            if (en_cnt > 1) n_onehot_err++;
            if (shift_en && key_round == 4'd10) final_shift_seen = 1'b1;
            if (mix_en && final_shift_seen) n_mix_late++;
            prev_kreq = key_req;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enables"}, int'({load_en, sub_en, shift_en, mix_en, ark_en}), 0);
        chk({tag, "_key_req"}, int'(key_req), 0);
        chk({tag, "_key_round"}, int'(key_round), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("rst_load_en", int'(load_en), 1);
        start = 1'b0;
        #1;
        chk_all_zero("in_reset");
        rst = 1'b0;

        // Nominal run, key_valid always high
        run(53, -1, 0, -1, -1);
        chk("nom_busy0", busy0, 0);
        chk("nom_load", n_load, 1);
        chk("nom_done_at", done_at, 52);
        chk("nom_done_cnt", n_done, 1);
        chk("nom_mix", n_mix, 9);
        chk("nom_sub", n_sub, 10);
        chk("nom_shift", n_shift, 10);
        chk("nom_ark", n_ark, 11);
        chk("nom_onehot", n_onehot_err, 0);
        chk("nom_mix_final", n_mix_late, 0);
        chk("nom_keyseq_len", keyseq.size(), 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("nom_keyseq_%0d", i), (i < keyseq.size()) ? keyseq[i] : -1, i);

        // Key wait of 3 cycles on round 4
        run(56, 4, 3, -1, -1);
        chk("wait_kreq4", n_kreq4, 4);
        chk("wait_done_at", done_at, 55);
        chk("wait_ark", n_ark, 11);

        // start re-pulsed mid-run and during DONE is ignored
        run(53, -1, 0, 10, 52);
        chk("restart_load", n_load, 1);
        chk("restart_done_at", done_at, 52);
        // immediate restart from the IDLE cycle after DONE
        run(53, -1, 0, -1, -1);
        chk("restart2_busy0", busy0, 0);
        chk("restart2_load", n_load, 1);
        chk("restart2_done_at", done_at, 52);

        // Asynchronous reset mid-run
        run(20, -1, 0, -1, -1);
        @(negedge clk);
        start = 1'b0;
        chk("prerst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        chk("async_rst_no_done", n_done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(53, -1, 0, -1, -1);
        chk("post_rst_done_at", done_at, 52);
        chk("post_rst_ark", n_ark, 11);

`ifdef AES_CTRL_ABORT_EN
        run(30, -1, 0, -1, -1);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        #1;
        chk("abort_busy_before", int'(busy), 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_busy_after", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_key_round", int'(key_round), 0);
        chk("abort_no_done_before", n_done, 0);
        run(53, -1, 0, -1, -1);
        chk("post_abort_done_at", done_at, 52);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
